// File: rtl/memory_arbiter.sv
// Arbiter sharing one RAM port between the instruction-fetch and data-memory ports.
// Data wins by default; a run of data transfers while fetch waits eventually forces a fetch grant.
module memory_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        mem_err
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C  = CNT_W'(0);

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IGRANT = 2'd1,
    ST_DGRANT = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] scnt_r;
  logic [CNT_W-1:0] scnt_next_s;
  logic             mem_err_r;
  logic             mem_err_next_s;

  logic dreq_s;
  logic access_s;
  logic error_s;
  logic i_done_s;
  logic d_done_s;

  // Request/RAM status decode shared by the FSM and the counter.
  always_comb begin
    dreq_s   = dREN | dWEN;
    access_s = (ramstate == RS_ACCESS);
    error_s  = (ramstate == RS_ERROR);
    // A withdrawn request never counts as a completed transfer.
    i_done_s = (state_r == ST_IGRANT) && iREN && access_s;
    d_done_s = (state_r == ST_DGRANT) && dreq_s && access_s;
  end

  // Grant state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state selection: arbitration happens only in IDLE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (dreq_s && (!iREN || (scnt_r < LIMIT_C))) begin
          state_next_s = ST_DGRANT;
        end else if (iREN) begin
          state_next_s = ST_IGRANT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_IGRANT: begin
        if (!iREN || access_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_IGRANT;
        end
      end
      ST_DGRANT: begin
        if (!dreq_s || access_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DGRANT;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // RAM-side drive and stall outputs, combinational from state and live requests.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'h0000_0000;
    ramstore = 32'h0000_0000;
    iwait    = 1'b1;
    dwait    = 1'b1;
    case (state_r)
      ST_IDLE: begin
        ramREN = 1'b0;
      end
      ST_IGRANT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iwait   = ~access_s;
      end
      ST_DGRANT: begin
        // A write takes precedence over a simultaneous read.
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dwait    = ~access_s;
      end
      default: begin
        ramREN = 1'b0;
      end
    endcase
  end

  // Starvation counter next value: changes only on a completed transfer.
  always_comb begin
    scnt_next_s = scnt_r;
    if (d_done_s) begin
      if (iREN) begin
        scnt_next_s = (scnt_r < LIMIT_C) ? (scnt_r + ONE_C) : LIMIT_C;
      end else begin
        scnt_next_s = ZERO_C;
      end
    end else if (i_done_s) begin
      scnt_next_s = ZERO_C;
    end else begin
      scnt_next_s = scnt_r;
    end
  end

  // Starvation counter register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      scnt_r <= ZERO_C;
    end else begin
      scnt_r <= scnt_next_s;
    end
  end

  // Sticky error flag: any ERROR seen while a grant is held.
  always_comb begin
    if ((state_r != ST_IDLE) && error_s) begin
      mem_err_next_s = 1'b1;
    end else begin
      mem_err_next_s = mem_err_r;
    end
  end

  // Error flag register, cleared only by reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mem_err_r <= 1'b0;
    end else begin
      mem_err_r <= mem_err_next_s;
    end
  end

  assign iload   = ramload;
  assign dload   = ramload;
  assign mem_err = mem_err_r;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus randomized requesters,
// compared each cycle against a transaction-level model of who owns the RAM port.
module tb_memory_arbiter;

  localparam int LIMIT = 4;
  localparam logic [1:0] RS_FREE   = 2'd0;
  localparam logic [1:0] RS_BUSY   = 2'd1;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;
  localparam int OWN_NONE = 0;
  localparam int OWN_I    = 1;
  localparam int OWN_D    = 2;

  logic        CLK;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        mem_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: current owner of the port, data transfers served while fetch waited, error seen.
  int owner    = OWN_NONE;
  int data_run = 0;
  bit err_seen = 1'b0;
  bit li_wait  = 1'b1;
  bit ld_wait  = 1'b1;

  memory_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .mem_err(mem_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic        e_ren, e_wen, e_iw, e_dw;
    logic [31:0] e_addr, e_store;
    e_ren = 1'b0; e_wen = 1'b0; e_iw = 1'b1; e_dw = 1'b1;
    e_addr = 32'h0; e_store = 32'h0;
    if (owner == OWN_I) begin
      e_ren  = iREN;
      e_addr = iaddr;
      e_iw   = (ramstate != RS_ACCESS);
    end else if (owner == OWN_D) begin
      e_wen   = dWEN;
      e_ren   = dREN && !dWEN;
      e_addr  = daddr;
      e_store = dstore;
      e_dw    = (ramstate != RS_ACCESS);
    end
    check_eq("ramREN", ramREN, e_ren);
    check_eq("ramWEN", ramWEN, e_wen);
    check_eq("ramaddr", ramaddr, e_addr);
    check_eq("ramstore", ramstore, e_store);
    check_eq("iwait", iwait, e_iw);
    check_eq("dwait", dwait, e_dw);
    check_eq("iload", iload, ramload);
    check_eq("dload", dload, ramload);
    check_eq("mem_err", mem_err, err_seen);
    li_wait = iwait;
    ld_wait = dwait;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_update();
    bit dreq;
    dreq = dREN || dWEN;
    if (owner == OWN_NONE) begin
      if (dreq && (!iREN || data_run < LIMIT)) owner = OWN_D;
      else if (iREN) owner = OWN_I;
    end else begin
      if (ramstate == RS_ERROR) err_seen = 1'b1;
      if (owner == OWN_I) begin
        if (!iREN) owner = OWN_NONE;
        else if (ramstate == RS_ACCESS) begin
          data_run = 0;
          owner = OWN_NONE;
        end
      end else begin
        if (!dreq) owner = OWN_NONE;
        else if (ramstate == RS_ACCESS) begin
          data_run = iREN ? ((data_run + 1 > LIMIT) ? LIMIT : data_run + 1) : 0;
          owner = OWN_NONE;
        end
      end
    end
  endtask

  task automatic model_reset();
    owner = OWN_NONE;
    data_run = 0;
    err_seen = 1'b0;
  endtask

  // One cycle: called at a negedge with inputs already set, returns at the next negedge.
  task automatic tick();
    #2;
    compare_model();
    @(posedge CLK);
    if (nRST) model_update();
    @(negedge CLK);
  endtask

  task automatic drop_all();
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = RS_FREE;
  endtask

  initial begin
    int seq_q[$];
    nRST = 1'b0; iREN = 1'b0; iaddr = 32'h0; dREN = 1'b0; dWEN = 1'b0;
    daddr = 32'h0; dstore = 32'h0; ramload = 32'h1234_5678; ramstate = RS_FREE;
    model_reset();
    #3;
    check_eq("rst_ramREN", ramREN, 1'b0);
    check_eq("rst_ramWEN", ramWEN, 1'b0);
    check_eq("rst_ramaddr", ramaddr, 32'h0);
    check_eq("rst_iwait", iwait, 1'b1);
    check_eq("rst_dwait", dwait, 1'b1);
    check_eq("rst_mem_err", mem_err, 1'b0);
    check_eq("rst_iload", iload, 32'h1234_5678);
    @(negedge CLK);
    nRST = 1'b1;
    tick();

    // Instruction-only read with two BUSY cycles.
    iREN = 1'b1; iaddr = 32'h40; ramload = 32'h8C02_0004; ramstate = RS_FREE;
    tick();
    ramstate = RS_BUSY; #1;
    check_eq("ifetch_ren_c1", ramREN, 1'b1);
    check_eq("ifetch_addr_c1", ramaddr, 32'h40);
    tick();
    ramstate = RS_BUSY; #1;
    check_eq("ifetch_wait_c2", iwait, 1'b1);
    tick();
    ramstate = RS_ACCESS; #1;
    check_eq("ifetch_wait_c3", iwait, 1'b0);
    check_eq("ifetch_load_c3", iload, 32'h8C02_0004);
    tick();
    drop_all(); #1;
    check_eq("ifetch_idle_c4", ramREN, 1'b0);
    tick();

    // Simultaneous requests: data first, an IDLE gap, then the fetch.
    iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h100;
    tick();
    ramstate = RS_ACCESS; #1;
    check_eq("simul_daddr", ramaddr, 32'h100);
    check_eq("simul_dwait", dwait, 1'b0);
    tick();
    dREN = 1'b0; ramstate = RS_FREE; #1;
    check_eq("simul_gap_ren", ramREN, 1'b0);
    tick();
    ramstate = RS_ACCESS; #1;
    check_eq("simul_iaddr", ramaddr, 32'h80);
    check_eq("simul_iwait", iwait, 1'b0);
    tick();
    drop_all();
    tick();

    // Write precedence over read.
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEAD_BEEF;
    tick();
    ramstate = RS_ACCESS; #1;
    check_eq("wr_ramWEN", ramWEN, 1'b1);
    check_eq("wr_ramREN", ramREN, 1'b0);
    check_eq("wr_ramstore", ramstore, 32'hDEAD_BEEF);
    check_eq("wr_dwait", dwait, 1'b0);
    tick();
    drop_all();
    tick();

    // Starvation: both held with immediate ACCESS; every fifth completion is the fetch.
    iREN = 1'b1; iaddr = 32'h1000; dREN = 1'b1; daddr = 32'h2000; ramstate = RS_ACCESS;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (!dwait) seq_q.push_back(0);
      else if (!iwait) seq_q.push_back(1);
      tick();
    end
    check_eq("starve_count", seq_q.size(), 10);
    foreach (seq_q[k]) check_eq("starve_seq", seq_q[k], ((k % 5) == 4) ? 1 : 0);
    drop_all();
    tick();

    // ERROR during a fetch grant: flag is sticky, grant held until ACCESS.
    iREN = 1'b1; iaddr = 32'h300;
    tick();
    ramstate = RS_ERROR; #1;
    check_eq("err_iwait_e1", iwait, 1'b1);
    check_eq("err_flag_pre", mem_err, 1'b0);
    tick();
    ramstate = RS_ERROR; #1;
    check_eq("err_flag_e2", mem_err, 1'b1);
    check_eq("err_hold_addr", ramaddr, 32'h300);
    tick();
    ramstate = RS_ACCESS; #1;
    check_eq("err_iwait_acc", iwait, 1'b0);
    tick();
    drop_all(); #1;
    check_eq("err_sticky", mem_err, 1'b1);
    tick();

    // Randomized requesters: a request is held until served, then may drop or change.
    for (int c = 0; c < 600; c++) begin
      ramstate = 2'($urandom_range(0, 2));
      ramload  = $urandom;
      tick();
      if (iREN && !li_wait) begin
        iREN = 1'($urandom_range(0, 1)); iaddr = $urandom;
      end else if (!iREN) begin
        iREN = ($urandom_range(0, 3) == 0); iaddr = $urandom;
      end
      if ((dREN || dWEN) && !ld_wait) begin
        {dREN, dWEN} = 2'($urandom_range(0, 3)); daddr = $urandom; dstore = $urandom;
      end else if (!(dREN || dWEN) && ($urandom_range(0, 3) == 0)) begin
        {dREN, dWEN} = 2'($urandom_range(1, 3)); daddr = $urandom; dstore = $urandom;
      end
    end
    drop_all();
    tick();
    tick();

    // Asynchronous reset in the middle of a BUSY data grant.
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h400; dstore = 32'h0BAD_F00D;
    tick();
    ramstate = RS_BUSY; #1;
    check_eq("rmid_wen_before", ramWEN, 1'b1);
    #1; nRST = 1'b0; #1;
    check_eq("rmid_ramWEN", ramWEN, 1'b0);
    check_eq("rmid_ramREN", ramREN, 1'b0);
    check_eq("rmid_dwait", dwait, 1'b1);
    check_eq("rmid_mem_err", mem_err, 1'b0);
    model_reset();
    @(negedge CLK);
    nRST = 1'b1; drop_all();
    tick();
    // Counter cleared: simultaneous requests go to data first.
    iREN = 1'b1; iaddr = 32'h500; dREN = 1'b1; daddr = 32'h600;
    tick();
    ramstate = RS_ACCESS; #1;
    check_eq("rpost_daddr", ramaddr, 32'h600);
    tick();
    drop_all();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Sequential arbiter sharing the single RAM port between the pipeline's instruction-fetch port and data-memory port. Registered grant FSM: data access has priority; a starvation counter forces an instruction grant after a bounded run of data grants. Sits between the pipelined datapath (fetch/MEM stages) and RAM. Its wait outputs are the memory-side stall inputs that the hazard logic combines with its own stalls and flushes.

## Interface
- STARVE_LIMIT, 4: max consecutive completed data transfers while iREN is pending before an instruction grant is forced (≥1).
- CLK  in  1  clock; all state updates on rising edge.
- nRST  in  1  reset; asynchronous, active-low.
- iREN  in  1  instruction read request.
- iaddr  in  32  instruction address (word_t).
- iload  out  32  instruction read data.
- iwait  out  1  instruction port stall.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  32  data address.
- dstore  in  32  data write value.
- dload  out  32  data read data.
- dwait  out  1  data port stall.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- mem_err  out  1  sticky flag; RAM reported ERROR during a grant.

## Operation
- States: IDLE, IGRANT, DGRANT. Counter scnt has range 0..STARVE_LIMIT and saturates.
- IDLE:
  - dreq = dREN|dWEN.
  - If dreq and (!iREN or scnt<STARVE_LIMIT), go to DGRANT.
  - Else if iREN, go to IGRANT.
  - Else stay in IDLE.
- IDLE outputs: ramREN=ramWEN=0, ramaddr=0, ramstore=0.
- IGRANT outputs: ramREN=iREN, ramWEN=0, ramaddr=iaddr, ramstore=0.
- DGRANT outputs: ramWEN=dWEN, ramREN=dREN&!dWEN (a write beats a read), ramaddr=daddr, ramstore=dstore.
- RAM-side outputs are combinational from state and the live requester inputs.
- Completion: ramstate==ACCESS in a grant state.
  - Same cycle: the granted wait goes low.
  - Next edge: FSM returns to IDLE.
- Waits:
  - iwait=0 only in IGRANT with ramstate==ACCESS; otherwise 1.
  - dwait=0 only in DGRANT with ramstate==ACCESS; otherwise 1.
  - Both are 1 in IDLE.
- Read data: iload=ramload and dload=ramload, unconditionally.
- Request withdrawn in a grant state (IGRANT with iREN=0, or DGRANT with dREN=dWEN=0):
  - RAM enables drop the same cycle.
  - FSM returns to IDLE next edge.
  - No counter update.
- scnt update, on completion only:
  - Data completion with iREN=1: scnt=min(scnt+1, STARVE_LIMIT).
  - Data completion with iREN=0: scnt=0.
  - Instruction completion: scnt=0.
- ramstate ERROR in a grant state: set mem_err (cleared only by reset) and keep waiting. The grant is not released.
- FREE or BUSY in a grant state: hold the grant, wait stays 1.

## Timing
- Reset (nRST low, asynchronous): state=IDLE, scnt=0, mem_err=0.
- Outputs during reset: ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1. iload and dload follow ramload.
- Minimum transfer is 2 cycles:
  - Cycle 0: request seen in IDLE.
  - Cycle 1: grant drives RAM; wait low if ramstate==ACCESS.
- Each extra BUSY cycle adds one cycle.
- No back-to-back grants: at least one IDLE cycle between transfers.
- Simultaneous iREN and dreq in IDLE: data wins unless scnt==STARVE_LIMIT.
- Requests change only in IDLE: a new dreq arriving during IGRANT is not observed until IDLE.
- nRST asserted mid-grant: RAM enables drop immediately; the pending transfer is abandoned. Requesters re-present after reset.

## Test plan
- Instruction-only read: iREN=1, iaddr=0x40, RAM gives BUSY,BUSY,ACCESS with ramload=0x8C020004. Required: ramREN=1, ramaddr=0x40 from cycle 1; iwait=0 only in cycle 3 with iload=0x8C020004; IDLE in cycle 4.
- Simultaneous requests: iREN=1 and dREN=1 (daddr=0x100), RAM ACCESS on first grant cycle. Required: DGRANT first (ramaddr=0x100, dwait pulses low); then IDLE; then IGRANT (ramaddr=iaddr).
- Starvation, STARVE_LIMIT=4: iREN and dREN held high continuously. Required: exactly 4 data completions, then 1 instruction completion (scnt reaches 4, then returns to 0), and the pattern repeats.
- Write precedence: dREN=dWEN=1, daddr=0x200, dstore=0xDEADBEEF. Required: ramWEN=1, ramREN=0, ramstore=0xDEADBEEF; dwait low on ACCESS.
- Reset mid-grant: in DGRANT with BUSY, drop nRST asynchronously between edges. Required: ramWEN/ramREN go to 0 and dwait to 1 without waiting for a clock edge; after release, state=IDLE and scnt=0.
- Error: in IGRANT, ramstate=ERROR for 2 cycles then ACCESS. Required: mem_err=1 from the first ERROR edge and held; iwait=1 during ERROR, 0 on ACCESS; mem_err clears only on nRST.
